// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the load/store data memory.
// Access sizes follow the RV32 funct3 low bits; 2'b11 is treated as illegal.
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10
   } size_e;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_e;

   // Lanes touched by an access; an illegal size enables nothing.
   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
      logic [3:0] be;
      case (size)
         SZ_B:    be = 4'b0001 << lane;
         SZ_H:    be = 4'b0011 << lane;
         SZ_W:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic uns);
      logic [31:0] sh;
      logic [31:0] res;
      sh = word >> {lane, 3'b000};
      case (size)
         SZ_B:    res = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         SZ_H:    res = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: res = word;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store data replication and byte enables,
// and load data shift plus sign/zero extension.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_lane,
   input  logic [31:0] st_wdata,
   output logic [31:0] st_data,
   output logic [3:0]  st_be,
   input  logic [1:0]  ld_size,
   input  logic [1:0]  ld_lane,
   input  logic        ld_uns,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   // Replicating the right-aligned store data lets the byte enables alone pick the lanes.
   always_comb begin
      case (st_size)
         SZ_B:    st_data = {4{st_wdata[7:0]}};
         SZ_H:    st_data = {2{st_wdata[15:0]}};
         default: st_data = st_wdata;
      endcase
      st_be   = byte_en(st_size, st_lane);
      ld_data = load_extend(ld_word, ld_size, ld_lane, ld_uns);
   end

endmodule

// File: rtl/dmem_lsu.sv
// Handshaked byte-addressable data memory for the memory stage, with a
// sequential post-reset clear and registered single-cycle responses.
module dmem_lsu
   import dmem_pkg::*;
#(
   parameter int DEPTH          = 1024,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int IDX_W = $clog2(DEPTH);

   state_e            state;
   logic [IDX_W-1:0]  clr_idx;
   logic [31:0]       mem [DEPTH];
   logic [31:0]       rd_word;

   logic              accept;
   logic              req_err;
   logic [IDX_W-1:0]  req_word;
   logic [1:0]        req_lane;
   logic [31:0]       st_data;
   logic [3:0]        st_be;
   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic [31:0]       wr_data;
   logic [3:0]        wr_be;

   logic              rsp_load;
   logic [1:0]        rsp_size;
   logic [1:0]        rsp_lane;
   logic              rsp_uns;
   logic [31:0]       ld_data;

   assign req_ready = (state == ST_READY) && !rst;
   assign busy      = rst ? CLEAR_ON_RESET : (state == ST_CLEAR);
   assign accept    = req_valid && req_ready;
   assign req_word  = req_addr[IDX_W+1:2];
   assign req_lane  = req_addr[1:0];

   always_comb begin
      req_err = 1'b0;
      if (req_size == 2'b11)                          req_err = 1'b1;
      if (req_size == SZ_H && req_lane[0])            req_err = 1'b1;
      if (req_size == SZ_W && req_lane != 2'b00)      req_err = 1'b1;
      if ((req_addr >> (IDX_W + 2)) != 32'h0)         req_err = 1'b1;
   end

   dmem_lane_align u_align (
      .st_size  (req_size),
      .st_lane  (req_lane),
      .st_wdata (req_wdata),
      .st_data  (st_data),
      .st_be    (st_be),
      .ld_size  (rsp_size),
      .ld_lane  (rsp_lane),
      .ld_uns   (rsp_uns),
      .ld_word  (rd_word),
      .ld_data  (ld_data)
   );

   // The clear sequence and stores share the single write port; rst drops any write.
   always_comb begin
      wr_en   = !rst && ((state == ST_CLEAR) || (accept && req_we && !req_err));
      wr_idx  = (state == ST_CLEAR) ? clr_idx : req_word;
      wr_be   = (state == ST_CLEAR) ? 4'b1111 : st_be;
      wr_data = (state == ST_CLEAR) ? 32'h0 : st_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
         clr_idx <= '0;
      end else if (state == ST_CLEAR) begin
         clr_idx <= clr_idx + 1'b1;
         if (clr_idx == IDX_W'(DEPTH - 1))
            state <= ST_READY;
      end
   end

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (wr_en && wr_be[b])
            mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      if (accept)
         rd_word <= mem[req_word];
   end

   // Extension happens after the synchronous read so the array stays a plain RAM.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_load  <= 1'b0;
         rsp_size  <= 2'b00;
         rsp_lane  <= 2'b00;
         rsp_uns   <= 1'b0;
      end else begin
         rsp_valid <= accept;
         rsp_err   <= accept && req_err;
         rsp_load  <= accept && !req_we && !req_err;
         if (accept) begin
            rsp_size <= req_size;
            rsp_lane <= req_lane;
            rsp_uns  <= req_unsigned;
         end
      end
   end

   assign rsp_rdata = rsp_load ? ld_data : 32'h0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: clear sequencing, sized loads/stores,
// error flagging, back-to-back throughput and reset interactions.
module tb_dmem_lsu;

   logic        clk;
   logic        rst, req_valid, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready, rsp_valid, rsp_err, busy;
   logic [31:0] rsp_rdata;

   logic        b_rst, b_req_valid, b_req_we, b_req_unsigned;
   logic [1:0]  b_req_size;
   logic [31:0] b_req_addr, b_req_wdata;
   logic        b_req_ready, b_rsp_valid, b_rsp_err, b_busy;
   logic [31:0] b_rsp_rdata;

   int tests_run = 0;
   int tests_failed = 0;

   dmem_lsu #(.DEPTH(16), .CLEAR_ON_RESET(1'b1)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
   );

   dmem_lsu #(.DEPTH(16), .CLEAR_ON_RESET(1'b0)) dut_nc (
      .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_we(b_req_we), .req_size(b_req_size), .req_unsigned(b_req_unsigned),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid),
      .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .busy(b_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata);
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic access(input string tag, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
      applyStimulus(we, size, uns, addr, wdata);
      checkOutput({tag, ".valid"}, 32'(rsp_valid), 32'd1);
      checkOutput({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
      checkOutput({tag, ".rdata"}, rsp_rdata, exp_rdata);
   endtask

   // Counts edges from release until req_ready, bounded so a stuck FSM still ends the run.
   task automatic waitReady(input string tag, input int expected);
      int n = 0;
      while (!req_ready && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput(tag, n, expected);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0;
      b_rst = 1'b1; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_size = 2'b10;
      b_req_unsigned = 1'b0; b_req_addr = 32'h0; b_req_wdata = 32'h0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst.ready", 32'(req_ready), 32'd0);
      checkOutput("rst.busy", 32'(busy), 32'd1);
      checkOutput("rst.valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst.err", 32'(rsp_err), 32'd0);
      checkOutput("rst.rdata", rsp_rdata, 32'h0);

      rst = 1'b0;
      waitReady("clear.edges", 16);
      checkOutput("clear.busy_done", 32'(busy), 32'd0);

      access("lw0", 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'h00000000, 1'b0);
      access("lw3c", 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, 32'h00000000, 1'b0);

      access("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h800000F0, 32'h0, 1'b0);
      access("lb10", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hFFFFFFF0, 1'b0);
      access("lbu13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h00000080, 1'b0);
      access("lh12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF8000, 1'b0);
      access("lhu10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h000000F0, 1'b0);

      access("sw20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0);
      access("sb21", 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA, 32'h0, 1'b0);
      access("sh22", 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, 32'h0, 1'b0);
      access("lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hBEEFAA44, 1'b0);

      access("err.lw22", 1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 32'h0, 1'b1);
      access("err.sh23", 1'b1, 2'b01, 1'b0, 32'h23, 32'h00001234, 32'h0, 1'b1);
      access("err.sz11", 1'b1, 2'b11, 1'b0, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b1);
      access("err.sw40", 1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, 32'h0, 1'b1);
      access("err.lw1000", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1);
      access("keep.lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hBEEFAA44, 1'b0);
      access("keep.lw0", 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'h00000000, 1'b0);
      @(posedge clk); #1;
      checkOutput("idle.valid", 32'(rsp_valid), 32'd0);

      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h4; req_wdata = 32'h5;
      @(posedge clk); #1;
      req_we = 1'b0;
      checkOutput("b2b.valid1", 32'(rsp_valid), 32'd1);
      checkOutput("b2b.rdata1", rsp_rdata, 32'h0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      checkOutput("b2b.valid2", 32'(rsp_valid), 32'd1);
      checkOutput("b2b.rdata2", rsp_rdata, 32'h00000005);
      @(posedge clk); #1;
      checkOutput("b2b.valid3", 32'(rsp_valid), 32'd0);

      rst = 1'b1;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h10; req_wdata = 32'h12345678;
      @(posedge clk); #1;
      req_valid = 1'b0;
      checkOutput("rststore.valid", 32'(rsp_valid), 32'd0);
      checkOutput("rststore.ready", 32'(req_ready), 32'd0);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("midclear.busy", 32'(busy), 32'd1);
      checkOutput("midclear.ready", 32'(req_ready), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      waitReady("midclear.edges", 16);
      access("clr.lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h00000000, 1'b0);
      access("clr.lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h00000000, 1'b0);

      // Instance without clearing: memory survives reset, so a dropped store is observable.
      checkOutput("nc.rst.busy", 32'(b_busy), 32'd0);
      checkOutput("nc.rst.ready", 32'(b_req_ready), 32'd0);
      b_rst = 1'b0;
      #1;
      checkOutput("nc.ready", 32'(b_req_ready), 32'd1);
      b_req_valid = 1'b1; b_req_we = 1'b1; b_req_size = 2'b10; b_req_addr = 32'h8; b_req_wdata = 32'h55;
      @(posedge clk); #1;
      b_req_valid = 1'b0;
      checkOutput("nc.sw.valid", 32'(b_rsp_valid), 32'd1);
      b_rst = 1'b1;
      b_req_valid = 1'b1; b_req_wdata = 32'h99;
      @(posedge clk); #1;
      b_req_valid = 1'b0; b_rst = 1'b0;
      checkOutput("nc.rststore.valid", 32'(b_rsp_valid), 32'd0);
      b_req_valid = 1'b1; b_req_we = 1'b0;
      @(posedge clk); #1;
      b_req_valid = 1'b0;
      checkOutput("nc.lw.valid", 32'(b_rsp_valid), 32'd1);
      checkOutput("nc.lw.rdata", b_rsp_rdata, 32'h00000055);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
